// File: rtl/peri_charlieplex_pwm.sv
// Charlieplexed LED matrix driver: per-pixel PWM brightness, double-buffered
// frame memory, and a Wishbone B4 register port that only reaches the back buffer.
module peri_charlieplex_pwm #(
  parameter int Pins         = 7,
  parameter int Rows         = 5,
  parameter int Cols         = 7,
  parameter int BrightBits   = 2,
  parameter int TicksPerStep = 1,
  parameter int AdrW         = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  output logic               wb_ack_o,
  input  logic [AdrW-1:0]    wb_adr_i,
  input  logic [7:0]         wb_dat_i,
  output logic [7:0]         wb_dat_o,
  output logic [Pins-1:0]    charlieplex_o,
  output logic [Pins-1:0]    charlieplex_out_en_o
);

  localparam int Steps = (1 << BrightBits) - 1;
  localparam int NPix  = Rows * Cols;
  localparam int TW    = (TicksPerStep > 1) ? $clog2(TicksPerStep) : 1;
  localparam int RW    = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int CW    = (Cols > 1) ? $clog2(Cols) : 1;
  localparam int PW    = (Pins > 1) ? $clog2(Pins) : 1;
  localparam logic [AdrW-1:0] AdrCtrl   = AdrW'((2 ** AdrW) - 2);
  localparam logic [AdrW-1:0] AdrStatus = AdrW'((2 ** AdrW) - 1);

  logic [BrightBits-1:0] back_buf  [NPix];
  logic [BrightBits-1:0] front_buf [NPix];
  logic                  enable;
  logic                  swap_pending;
  logic [5:0]            frame_cnt;

  // Scan position; pix tracks col*Rows+row, which is simply the slot index
  // because row is the faster-moving of the two.
  logic [TW-1:0]         tick;
  logic [BrightBits-1:0] step;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [AdrW-1:0]       pix;

  logic access, pix_wr, ctrl_wr, swap_req, do_swap;
  logic tick_last, step_last, row_last, col_last, frame_end;
  logic lit;
  logic [BrightBits-1:0] level;
  logic [PW-1:0]         row_pin, col_pin;
  logic [Pins-1:0]       row_bit, col_bit;
  logic [7:0]            rd_data;
  logic                  unused_dat;

  assign unused_dat = ^wb_dat_i;

  assign access   = wb_stb_i && !wb_ack_o;
  assign pix_wr   = access && wb_we_i && (wb_adr_i < AdrW'(NPix));
  assign ctrl_wr  = access && wb_we_i && (wb_adr_i == AdrCtrl);
  assign swap_req = ctrl_wr && wb_dat_i[1];

  assign tick_last = (tick == TW'(TicksPerStep - 1));
  assign step_last = (step == BrightBits'(Steps - 1));
  assign row_last  = (row == RW'(Rows - 1));
  assign col_last  = (col == CW'(Cols - 1));
  assign frame_end = enable && tick_last && step_last && row_last && col_last;

  // A request written on the frame-end clock is honoured at that same frame end.
  assign do_swap = enable ? (frame_end && (swap_pending || swap_req)) : swap_pending;

  assign level   = front_buf[pix];
  assign lit     = enable && (level > step) && !(step == '0 && tick == '0);
  assign col_pin = PW'(col);
  assign row_pin = (PW'(row) >= PW'(col)) ? PW'(row) + PW'(1) : PW'(row);
  assign row_bit = Pins'(1) << row_pin;
  assign col_bit = Pins'(1) << col_pin;

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    if (wb_adr_i < AdrW'(NPix))   rd_data = 8'(back_buf[wb_adr_i]);
    else if (wb_adr_i == AdrCtrl)   rd_data = {7'b0, enable};
    else if (wb_adr_i == AdrStatus) rd_data = {frame_cnt, 1'b0, swap_pending};
  end

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: frame memory is cleared in reset because a reset must blank the display.
      for (int i = 0; i < NPix; i++) begin
        back_buf[i]  <= '0;
        front_buf[i] <= '0;
      end
      enable               <= 1'b0;
      swap_pending         <= 1'b0;
      frame_cnt            <= '0;
      tick                 <= '0;
      step                 <= '0;
      row                  <= '0;
      col                  <= '0;
      pix                  <= '0;
      wb_ack_o             <= 1'b0;
      wb_dat_o             <= '0;
      charlieplex_o        <= '0;
      charlieplex_out_en_o <= '0;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= access ? rd_data : 8'h00;

      if (pix_wr) back_buf[wb_adr_i] <= wb_dat_i[BrightBits-1:0];
      if (ctrl_wr) enable <= wb_dat_i[0];

      // The copy takes a coinciding back-buffer write into account.
      if (do_swap) begin
        for (int i = 0; i < NPix; i++)
          front_buf[i] <= (pix_wr && wb_adr_i == AdrW'(i)) ? wb_dat_i[BrightBits-1:0]
                                                           : back_buf[i];
      end

      if (do_swap)       swap_pending <= 1'b0;
      else if (swap_req) swap_pending <= 1'b1;

      if (frame_end) frame_cnt <= frame_cnt + 1'b1;

      if (!enable) begin
        tick <= '0;
        step <= '0;
        row  <= '0;
        col  <= '0;
        pix  <= '0;
      end else if (!tick_last) begin
        tick <= tick + 1'b1;
      end else begin
        tick <= '0;
        if (!step_last) begin
          step <= step + 1'b1;
        end else begin
          step <= '0;
          pix  <= frame_end ? '0 : pix + 1'b1;
          if (!row_last) begin
            row <= row + 1'b1;
          end else begin
            row <= '0;
            col <= col_last ? '0 : col + 1'b1;
          end
        end
      end

      charlieplex_o        <= lit ? row_bit : '0;
      charlieplex_out_en_o <= lit ? (row_bit | col_bit) : '0;
    end
  end

endmodule

// File: tb/tb_peri_charlieplex_pwm.sv
// Bench for peri_charlieplex_pwm: Wishbone reads are scored against a queue of
// expected values; pin activity is counted over whole frames.
module tb_peri_charlieplex_pwm;

  localparam int Tps   = 2;
  localparam int Frame = 5 * 7 * 3 * Tps;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we  = 1'b0;
  logic       stb = 1'b0;
  logic [5:0] adr = '0;
  logic [7:0] dat = '0;
  logic       ack;
  logic [7:0] dat_o;
  logic [6:0] cp, en;

  peri_charlieplex_pwm #(
    .Pins(7), .Rows(5), .Cols(7), .BrightBits(2), .TicksPerStep(Tps), .AdrW(6)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wb_we_i(we), .wb_stb_i(stb), .wb_ack_o(ack),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat_o),
    .charlieplex_o(cp), .charlieplex_out_en_o(en)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
    logic [7:0] mask;
  } exp_t;
  exp_t sb[$];

  int unsigned edge_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    check({tag, "_ack"}, ack, 1);
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = a; dat = d;
    wait_ack("wr");
    edge_e = cyc;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [5:0] a, input logic [7:0] exp, input logic [7:0] mask,
                         input string tag);
    exp_t e;
    sb.push_back('{tag, exp, mask});
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = a;
    wait_ack(tag);
    e = sb.pop_front();
    check(e.tag, dat_o & e.mask, e.exp & e.mask);
    stb = 1'b0;
  endtask

  task automatic wait_lit(input int bound, output logic found);
    found = 1'b0;
    for (int n = 0; n < bound && !found; n++) begin
      @(negedge clk);
      if (en != '0) found = 1'b1;
    end
  endtask

  task automatic count_window(input int n, input logic [6:0] exp_en, input logic [6:0] exp_cp,
                              output int lit, output int bad);
    lit = 0;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (en != '0) begin
        lit++;
        if (en !== exp_en || cp !== exp_cp) bad++;
      end
    end
  endtask

  initial begin
    int          lit, bad;
    logic        found;
    int unsigned e;
    int          lit_exp [4] = '{0, 1, 3, 5};

    // Reset and idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_cp", cp, 0);
    check("idle_en", en, 0);
    check("idle_ack", ack, 0);
    check("idle_dat", dat_o, 0);
    wb_read(6'd63, 8'h00, 8'hFF, "status_reset");
    wb_read(6'd0,  8'h00, 8'hFF, "pix0_reset");
    wb_read(6'd62, 8'h00, 8'hFF, "ctrl_reset");

    // Register round trip and address decode boundaries
    wb_write(6'd12, 8'hFF);
    wb_read(6'd12, 8'h03, 8'hFF, "pix12_trunc");
    wb_write(6'd40, 8'h55);
    wb_read(6'd40, 8'h00, 8'hFF, "adr40_zero");
    wb_write(6'd35, 8'h03);
    wb_read(6'd35, 8'h00, 8'hFF, "adr35_zero");
    wb_write(6'd34, 8'h02);
    wb_read(6'd34, 8'h02, 8'hFF, "pix34_last");
    wb_read(6'd12, 8'h03, 8'hFF, "pix12_kept");
    wb_read(6'd0,  8'h00, 8'hFF, "pix0_kept");
    wb_read(6'd62, 8'h00, 8'hFF, "ctrl_kept");
    wb_write(6'd12, 8'h00);
    wb_write(6'd34, 8'h00);

    // Swap while enabled: takes effect only at frame end
    wb_write(6'd0, 8'h03);
    wb_write(6'd62, 8'h03);
    e = edge_e;
    wb_read(6'd63, 8'h01, 8'hFF, "status_pending");
    wb_read(6'd62, 8'h01, 8'hFF, "ctrl_enable_rd");
    wait_lit(3 * Frame, found);
    check("swap_seen", found, 1);
    check("swap_latency", cyc - e, Frame + 2);
    check("slot0_cp", cp, 7'h02);
    check("slot0_en", en, 7'h03);
    wb_read(6'd63, 8'h04, 8'hFF, "status_after_swap");
    count_window(Frame, 7'h03, 7'h02, lit, bad);
    check("slot0_lit_count", lit, 5);
    check("slot0_pattern", bad, 0);
    wb_read(6'd0, 8'h03, 8'hFF, "back_kept");

    // PWM levels on pixel 7 (row 2, col 1) via disabled swaps
    for (int lvl = 0; lvl < 4; lvl++) begin
      wb_write(6'd62, 8'h00);
      wb_write(6'd0, 8'h00);
      check("disabled_pins", en, 0);
      wb_write(6'd7, 8'(lvl));
      wb_write(6'd62, 8'h02);
      wb_read(6'd63, 8'h00, 8'h01, "dis_swap_cleared");
      wb_write(6'd62, 8'h01);
      count_window(Frame, 7'h0A, 7'h08, lit, bad);
      check($sformatf("pwm_lvl%0d_count", lvl), lit, lit_exp[lvl]);
      check($sformatf("pwm_lvl%0d_pattern", lvl), bad, 0);
    end

    // Mid-operation reset
    wait_lit(2 * Frame, found);
    check("pre_reset_lit", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_cp", cp, 0);
    check("reset_en", en, 0);
    @(negedge clk);
    rst = 1'b0;
    wb_read(6'd62, 8'h00, 8'hFF, "ctrl_after_reset");
    wb_read(6'd7,  8'h00, 8'hFF, "pix7_after_reset");
    wb_read(6'd63, 8'h00, 8'hFF, "status_after_reset");

    // 64 frames: frame_cnt wraps, cleared front buffer never lights
    wb_write(6'd62, 8'h01);
    e = edge_e;
    lit = 0;
    while (cyc < e + 63 * Frame + 10) begin
      @(negedge clk);
      if (en != '0) lit++;
    end
    wb_read(6'd63, 8'hFC, 8'hFF, "frame_cnt_63");
    while (cyc < e + 64 * Frame + 10) begin
      @(negedge clk);
      if (en != '0) lit++;
    end
    wb_read(6'd63, 8'h00, 8'hFF, "frame_cnt_wrap");
    check("front_cleared_lit", lit, 0);
    wb_write(6'd62, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
